// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with 16x oversampling, 2-FF rx synchronizer and frame-error flag
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            busy
);

    // s must reach SB_TICK-1 for 1.5/2 stop bits, so widen beyond 4 bits when needed
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            rx_meta;
    logic            rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    // start detection ignores s_tick; a coincident tick is not counted
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == SW'(7)) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == SW'(15)) begin
                            s <= '0;
                            b <= {rx_s, b[DBIT-1:1]};
                            if (n == NW'(DBIT - 1))
                                state <= STOP;
                            else
                                n <= n + 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            dout         <= b;
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx driven by a mod-M tick generator
module tb_uart_rx;

    localparam int M       = 40;
    localparam int BIT_CLK = 16 * M;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       busy;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    int   tick_div = 0;
    logic tick_en  = 1'b1;

    // mod-M tick source; holding tick_en low freezes its phase as well
    always @(posedge clk) begin
        if (tick_en) begin
            if (tick_div == M - 1) begin
                tick_div <= 0;
                s_tick   <= 1'b1;
            end else begin
                tick_div <= tick_div + 1;
                s_tick   <= 1'b0;
            end
        end else begin
            s_tick <= 1'b0;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       fe;
        longint     ticks;
    } cap_t;

    int     vectors    = 0;
    int     miscompares = 0;
    int     strobe_cnt = 0;
    longint tick_cnt   = 0;
    cap_t       cap_q[$];
    logic [8:0] exp_q[$];

    always @(negedge clk) begin
        if (s_tick) tick_cnt++;
        if (rx_done_tick) begin
            strobe_cnt++;
            cap_q.push_back('{d: dout, fe: frame_err, ticks: tick_cnt});
        end
    end

    task automatic drive_bit(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    // full frame; a low stop bit is released shortly after its midpoint so the
    // receiver's restart is rejected as a glitch rather than becoming a frame
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_q.push_back({~stop, d});
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLK);
        if (stop) begin
            drive_bit(1'b1, BIT_CLK);
        end else begin
            drive_bit(1'b0, BIT_CLK / 2 + 2 * M);
            drive_bit(1'b1, BIT_CLK / 2 - 2 * M);
        end
    endtask

    task automatic get_result(output cap_t c, output logic [8:0] e, output bit got);
        got = 1'b0;
        for (int i = 0; i < 2 * BIT_CLK && cap_q.size() == 0; i++) @(negedge clk);
        if (cap_q.size() != 0 && exp_q.size() != 0) begin
            c   = cap_q.pop_front();
            e   = exp_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        vectors += 4;
        if (rx_done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_strobe got=%b exp=0", rx_done_tick); end
        if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%h exp=00", dout); end
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_frame_55();
        cap_t c; logic [8:0] e; bit got; longint t0; int s0;
        t0 = tick_cnt;
        s0 = strobe_cnt;
        send_frame(8'h55, 1'b1);
        get_result(c, e, got);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL frame55_strobe got=none exp=1");
        end else begin
            vectors += 3;
            if (c.d !== e[7:0]) begin miscompares++; $display("FAIL frame55_dout got=%h exp=%h", c.d, e[7:0]); end
            if (c.fe !== e[8]) begin miscompares++; $display("FAIL frame55_frame_err got=%b exp=%b", c.fe, e[8]); end
            if (c.ticks - t0 < 151 || c.ticks - t0 > 153) begin
                miscompares++; $display("FAIL frame55_latency got=%0d exp=152+/-1", c.ticks - t0);
            end
        end
        repeat (BIT_CLK) @(negedge clk);
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL frame55_busy_after got=%b exp=0", busy); end
        if (strobe_cnt - s0 !== 1) begin miscompares++; $display("FAIL frame55_strobe_count got=%0d exp=1", strobe_cnt - s0); end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = strobe_cnt;
        drive_bit(1'b0, 3 * M);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_during got=%b exp=1", busy); end
        drive_bit(1'b1, 2 * BIT_CLK);
        vectors += 3;
        if (strobe_cnt !== s0) begin miscompares++; $display("FAIL glitch_no_strobe got=%0d exp=%0d", strobe_cnt, s0); end
        if (dout !== 8'h55) begin miscompares++; $display("FAIL glitch_dout got=%h exp=55", dout); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_frame_err();
        cap_t c; logic [8:0] e; bit got; int s0;
        s0 = strobe_cnt;
        send_frame(8'hA3, 1'b0);
        drive_bit(1'b1, BIT_CLK);
        send_frame(8'h11, 1'b1);
        drive_bit(1'b1, BIT_CLK);
        vectors++;
        if (strobe_cnt - s0 !== 2) begin miscompares++; $display("FAIL ferr_strobe_count got=%0d exp=2", strobe_cnt - s0); end
        for (int k = 0; k < 2; k++) begin
            get_result(c, e, got);
            vectors++;
            if (!got) begin
                miscompares++; $display("FAIL ferr_strobe%0d got=none exp=1", k);
            end else begin
                vectors += 2;
                if (c.d !== e[7:0]) begin miscompares++; $display("FAIL ferr_dout%0d got=%h exp=%h", k, c.d, e[7:0]); end
                if (c.fe !== e[8]) begin miscompares++; $display("FAIL ferr_flag%0d got=%b exp=%b", k, c.fe, e[8]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        cap_t c; logic [8:0] e; bit got; longint t_prev;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        t_prev = 0;
        for (int k = 0; k < 2; k++) begin
            get_result(c, e, got);
            vectors++;
            if (!got) begin
                miscompares++; $display("FAIL b2b_strobe%0d got=none exp=1", k);
            end else begin
                vectors += 2;
                if (c.d !== e[7:0]) begin miscompares++; $display("FAIL b2b_dout%0d got=%h exp=%h", k, c.d, e[7:0]); end
                if (c.fe !== e[8]) begin miscompares++; $display("FAIL b2b_flag%0d got=%b exp=%b", k, c.fe, e[8]); end
                if (k == 1) begin
                    vectors++;
                    if (c.ticks - t_prev < 159 || c.ticks - t_prev > 161) begin
                        miscompares++; $display("FAIL b2b_spacing got=%0d exp=160+/-1", c.ticks - t_prev);
                    end
                end
                t_prev = c.ticks;
            end
        end
        drive_bit(1'b1, BIT_CLK);
    endtask

    task automatic test_reset_mid_frame();
        cap_t c; logic [8:0] e; bit got; int s0;
        logic [7:0] d;
        d  = 8'h3C;
        s0 = strobe_cnt;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLK);
        drive_bit(d[4], BIT_CLK / 2);
        rst = 1'b1;
        #1;
        vectors += 3;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        if (dout !== 8'h00) begin miscompares++; $display("FAIL rstmid_dout got=%h exp=00", dout); end
        if (rx_done_tick !== 1'b0) begin miscompares++; $display("FAIL rstmid_strobe got=%b exp=0", rx_done_tick); end
        @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 2 * BIT_CLK);
        vectors++;
        if (strobe_cnt !== s0) begin miscompares++; $display("FAIL rstmid_no_strobe got=%0d exp=%0d", strobe_cnt, s0); end
        send_frame(d, 1'b1);
        get_result(c, e, got);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL rstmid_refr_strobe got=none exp=1");
        end else begin
            vectors += 2;
            if (c.d !== e[7:0]) begin miscompares++; $display("FAIL rstmid_refr_dout got=%h exp=%h", c.d, e[7:0]); end
            if (c.fe !== e[8]) begin miscompares++; $display("FAIL rstmid_refr_flag got=%b exp=%b", c.fe, e[8]); end
        end
        drive_bit(1'b1, BIT_CLK);
    endtask

    task automatic test_tick_freeze();
        cap_t c; logic [8:0] e; bit got; int s0;
        logic [7:0] d;
        d  = 8'h96;
        s0 = strobe_cnt;
        exp_q.push_back({1'b0, d});
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 3; i++) drive_bit(d[i], BIT_CLK);
        drive_bit(d[3], BIT_CLK / 2);
        tick_en = 1'b0;
        repeat (1000) @(negedge clk);
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL freeze_busy got=%b exp=1", busy); end
        if (strobe_cnt !== s0) begin miscompares++; $display("FAIL freeze_no_strobe got=%0d exp=%0d", strobe_cnt, s0); end
        tick_en = 1'b1;
        drive_bit(d[3], BIT_CLK / 2);
        for (int i = 4; i < 8; i++) drive_bit(d[i], BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        get_result(c, e, got);
        vectors++;
        if (!got) begin
            miscompares++; $display("FAIL freeze_strobe got=none exp=1");
        end else begin
            vectors += 2;
            if (c.d !== e[7:0]) begin miscompares++; $display("FAIL freeze_dout got=%h exp=%h", c.d, e[7:0]); end
            if (c.fe !== e[8]) begin miscompares++; $display("FAIL freeze_flag got=%b exp=%b", c.fe, e[8]); end
        end
        drive_bit(1'b1, BIT_CLK);
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_freeze();
        vectors++;
        if (cap_q.size() != 0) begin
            miscompares++; $display("FAIL leftover_strobes got=%0d exp=0", cap_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
